// File: rtl/uart_buffered.sv
// Single-clock, 16x-oversampled UART with RX/TX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add a parity bit to every frame (odd when PARITY_ODD=1).
module uart_buffered #(
    parameter int DIV        = 651,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 I_rst_n,
    input  logic                 rdn,
    input  logic                 wrn,
    input  logic [DATA_BITS-1:0] d_in,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 r_ready,
    output logic                 t_empty,
    output logic                 t_full,
    input  logic                 rxd,
    output logic                 txd,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [AW:0]  PTR_ONE  = (AW+1)'(1);
    localparam logic [3:0]   LAST_BIT = 4'(DATA_BITS - 1);

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    logic [CW-1:0] div_cnt_q;
    logic          tick;

    assign tick = (div_cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n)  div_cnt_q <= '0;
        else if (tick) div_cnt_q <= '0;
        else           div_cnt_q <= div_cnt_q + CW'(1);
    end

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW:0]          tx_wr_ptr_q, tx_rd_ptr_q;
    logic                 tx_fifo_empty, tx_fifo_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_fifo_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_fifo_full  = (tx_wr_ptr_q[AW] != tx_rd_ptr_q[AW]) &&
                           (tx_wr_ptr_q[AW-1:0] == tx_rd_ptr_q[AW-1:0]);
    assign tx_push       = !wrn && !tx_fifo_full;
    assign tx_head       = tx_mem_q[tx_rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q[AW-1:0]] <= d_in;
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
        end
    end

    tx_state_t            tx_state_q, tx_state_d;
    logic [3:0]           tx_tcnt_q, tx_tcnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;
    logic                 tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        // 4-bit tick counter wraps every 16 ticks, i.e. once per bit time.
        if (tick && tx_state_q != TX_IDLE) tx_tcnt_d = tx_tcnt_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tick && !tx_fifo_empty) tx_load = 1'b1;
            end
            TX_START: begin
                if (tick && tx_tcnt_q == 4'd15) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 4'd0;
                    txd_d      = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tick && tx_tcnt_q == 4'd15) begin
                    if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tick && tx_tcnt_q == 4'd15) begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tick && tx_tcnt_q == 4'd15) begin
                    if (!tx_fifo_empty) tx_load = 1'b1;
                    else                tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Loading from STOP chains frames with no idle gap.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            txd_d      = 1'b0;
            tx_tcnt_d  = 4'd0;
            tx_state_d = TX_START;
`ifdef UART_PARITY_EN
            tx_par_d   = par_bit(tx_head);
`endif
        end
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign t_full  = tx_fifo_full;
    assign t_empty = tx_fifo_empty && (tx_state_q == TX_IDLE);

    logic rx_s1_q, rx_s2_q;

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
        end
    end

    rx_state_t            rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_done;
`ifdef UART_PARITY_EN
    logic                 rx_perr_set;
`endif

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_set = 1'b0;
`endif
        if (tick && rx_state_q != RX_IDLE) rx_tcnt_d = rx_tcnt_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = 4'd0;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit.
                if (tick && rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d  = 4'd0;
                    rx_bit_d   = 4'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && rx_tcnt_q == 4'd15) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick && rx_tcnt_q == 4'd15) begin
                    rx_perr_set = (rx_s2_q != par_bit(rx_shift_q));
                    rx_state_d  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (tick && rx_tcnt_q == 4'd15) begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX FIFO: a pop in the same cycle frees the slot a full-FIFO push lands in.
    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW:0]          rx_wr_ptr_q, rx_rd_ptr_q;
    logic                 rx_fifo_empty, rx_fifo_full, rx_push, rx_pop, rx_drop;

    assign rx_fifo_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_fifo_full  = (rx_wr_ptr_q[AW] != rx_rd_ptr_q[AW]) &&
                           (rx_wr_ptr_q[AW-1:0] == rx_rd_ptr_q[AW-1:0]);
    assign rx_pop        = !rdn && !rx_fifo_empty;
    assign rx_push       = rx_done && (!rx_fifo_full || rx_pop);
    assign rx_drop       = rx_done && rx_fifo_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
        end
    end

    assign r_ready = !rx_fifo_empty;
    assign d_out   = rx_fifo_empty ? '0 : rx_mem_q[rx_rd_ptr_q[AW-1:0]];

    logic frame_error_q, frame_error_d;
    logic overrun_q, overrun_d;

    // A new error in the same cycle as a read strobe stays visible.
    always_comb begin
        frame_error_d = rdn ? frame_error_q : 1'b0;
        overrun_d     = rdn ? overrun_q : 1'b0;
        if (rx_done && !rx_s2_q) frame_error_d = 1'b1;
        if (rx_drop)             overrun_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

`ifdef UART_PARITY_EN
    logic parity_error_q, parity_error_d;

    always_comb begin
        parity_error_d = rdn ? parity_error_q : 1'b0;
        if (rx_perr_set) parity_error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) parity_error_q <= 1'b0;
        else          parity_error_q <= parity_error_d;
    end

    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered at DIV=4: TX waveform table, loopback scoreboard,
// overrun/backpressure, frame error, false start, parity and mid-frame reset.
module tb_uart_buffered;

    localparam int DIV   = 4;
    localparam int BIT   = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam int P     = 1;
`else
    localparam int P     = 0;
`endif
    localparam int FRAME = (10 + P) * BIT;

    logic       clk = 1'b0;
    logic       I_rst_n = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic       r_ready, t_empty, t_full, txd;
    logic       frame_error, parity_error, overrun;
    logic       loop = 1'b0;
    logic       rxd_drv = 1'b1;
    logic       rxd_w;

    assign rxd_w = loop ? txd : rxd_drv;

    uart_buffered #(
        .DIV        (DIV),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk          (clk),
        .I_rst_n      (I_rst_n),
        .rdn          (rdn),
        .wrn          (wrn),
        .d_in         (d_in),
        .d_out        (d_out),
        .r_ready      (r_ready),
        .t_empty      (t_empty),
        .t_full       (t_full),
        .rxd          (rxd_w),
        .txd          (txd),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        int   off;
        logic txd;
        logic te;
    } tx_vec_t;

    tx_vec_t tv [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; back-to-back calls keep wrn low on consecutive clocks.
    task automatic write_byte(input logic [7:0] b);
        d_in = b;
        wrn  = 1'b0;
        @(negedge clk);
        wrn  = 1'b1;
    endtask

    task automatic read_check(input string name);
        logic [7:0] e;
        chk({name, "_ready"}, r_ready, 1);
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk(name, d_out, e);
        end
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (t_empty) break;
            @(negedge clk);
        end
        chk({name, "_idle"}, t_empty, 1);
    endtask

    task automatic wait_txd_low(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!txd) break;
        end
        chk({name, "_start"}, txd, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        rxd_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (P == 1) begin
            rxd_drv = par;
            repeat (BIT) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (BIT) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic chk_flags(input string name);
        chk({name, "_ferr"}, frame_error, 0);
        chk({name, "_perr"}, parity_error, 0);
        chk({name, "_ovr"}, overrun, 0);
    endtask

    initial begin
        logic [7:0] b55;
        int cur;
        b55 = 8'h55;

        tv.push_back('{32, 1'b0, 1'b0});
        tv.push_back('{63, 1'b0, 1'b0});
        tv.push_back('{64, b55[0], 1'b0});
        for (int k = 0; k < 8; k++) tv.push_back('{BIT * (k + 1) + 32, b55[k], 1'b0});
        if (P == 1) tv.push_back('{BIT * 9 + 32, ^b55, 1'b0});
        tv.push_back('{BIT * (9 + P) + 32, 1'b1, 1'b0});
        tv.push_back('{FRAME - 1, 1'b1, 1'b0});
        tv.push_back('{FRAME, 1'b1, 1'b1});

        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_t_empty", t_empty, 1);
        chk("rst_t_full", t_full, 0);
        chk("rst_r_ready", r_ready, 0);
        chk("rst_d_out", d_out, 0);
        chk_flags("rst");
        I_rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Transmit waveform of 0x55 against the offset table.
        write_byte(8'h55);
        chk("tx55_busy", t_empty, 0);
        wait_txd_low("tx55", DIV + 2);
        cur = 0;
        foreach (tv[i]) begin
            while (cur < tv[i].off) begin
                @(negedge clk);
                cur++;
            end
            chk($sformatf("tx55_txd@%0d", tv[i].off), txd, tv[i].txd);
            chk($sformatf("tx55_te@%0d", tv[i].off), t_empty, tv[i].te);
        end
        repeat (BIT) @(negedge clk);

        // Loopback of three back-to-back bytes.
        loop = 1'b1;
        write_byte(8'h12); exp_q.push_back(8'h12);
        write_byte(8'hA5); exp_q.push_back(8'hA5);
        write_byte(8'hFF); exp_q.push_back(8'hFF);
        wait_idle("lb3", 4 * FRAME);
        repeat (BIT) @(negedge clk);
        chk_flags("lb3");
        for (int i = 0; i < 3; i++) read_check($sformatf("lb3_rd%0d", i));
        chk("lb3_drained", r_ready, 0);

        // 17 bytes with no reads: RX overrun, TX backpressure.
        write_byte(8'h00); exp_q.push_back(8'h00);
        wait_txd_low("ovr", DIV + 2);
        for (int i = 1; i <= 16; i++) begin
            write_byte(8'(i));
            if (i < 16) exp_q.push_back(8'(i));
        end
        chk("ovr_t_full", t_full, 1);
        write_byte(8'h11);
        chk("ovr_t_full2", t_full, 1);
        wait_idle("ovr", 19 * FRAME);
        repeat (BIT) @(negedge clk);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ferr", frame_error, 0);
        chk("ovr_t_full_end", t_full, 0);
        for (int i = 0; i < 16; i++) read_check($sformatf("ovr_rd%0d", i));
        chk("ovr_drained", r_ready, 0);
        chk("ovr_cleared", overrun, 0);

        // Frame error: 0x3C with stop bit 0.
        loop = 1'b0;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        chk("ferr_flag", frame_error, 1);
        exp_q.push_back(8'h3C);
        read_check("ferr_data");
        chk("ferr_cleared", frame_error, 0);
        chk("ferr_drained", r_ready, 0);

        // False start: low for 4 ticks only, then a valid frame.
        rxd_drv = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("fstart_no_byte", r_ready, 0);
        chk_flags("fstart");
        send_frame(8'h5A, ^8'h5A, 1'b1);
        exp_q.push_back(8'h5A);
        chk_flags("fstart_next");
        read_check("fstart_next");

`ifdef UART_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1);
        chk("perr_flag", parity_error, 1);
        chk("perr_ferr", frame_error, 0);
        exp_q.push_back(8'h01);
        read_check("perr_data");
        chk("perr_cleared", parity_error, 0);
`endif

        // Reset in the middle of the data bits of 0xC3.
        loop = 1'b1;
        write_byte(8'hC3);
        wait_txd_low("mrst", DIV + 2);
        repeat (3 * BIT + 10) @(negedge clk);
        chk("mrst_txd_before", txd, 0);
        I_rst_n = 1'b0;
        #1;
        chk("mrst_txd", txd, 1);
        chk("mrst_t_empty", t_empty, 1);
        chk("mrst_t_full", t_full, 0);
        chk("mrst_r_ready", r_ready, 0);
        repeat (3) @(negedge clk);
        I_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        write_byte(8'hC3); exp_q.push_back(8'hC3);
        wait_idle("mrst", 2 * FRAME);
        repeat (BIT) @(negedge clk);
        chk_flags("mrst");
        read_check("mrst_data");
        chk("mrst_drained", r_ready, 0);
        chk("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_buffered.md
# uart_buffered

Parametrised, FIFO-buffered UART for the 100 MHz system clock. It replaces the derived-clock UART with a single-clock design: a baud-tick enable, 16x-oversampled receiver and transmitter, and RX/TX FIFOs of configurable depth. It sits between the CPU-side strobe bus (`rdn`/`wrn`) and the board serial pins. It adds error and overrun reporting and backpressure that the fixed 8-bit single-buffer UART lacks.

## Interface
- `DIV`, 651: system clocks per oversample tick. Tick rate is clk/DIV; baud is clk/(16·DIV), so 651 gives 9600 baud at 100 MHz. Minimum 2.
- `DATA_BITS`, 8: data bits per frame, legal 5..8.
- `FIFO_DEPTH`, 16: entries per FIFO; power of 2, ≥2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Only meaningful with `UART_PARITY_EN`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `I_rst_n`  in  1  asynchronous, active-low reset.
- `rdn`  in  1  active-low read strobe; pops the RX FIFO.
- `wrn`  in  1  active-low write strobe; pushes `d_in` into the TX FIFO.
- `d_in`  in  DATA_BITS  transmit data.
- `d_out`  out  DATA_BITS  RX FIFO head (first-word-fall-through); 0 when the RX FIFO is empty.
- `r_ready`  out  1  RX FIFO non-empty.
- `t_empty`  out  1  TX FIFO empty and transmitter idle.
- `t_full`  out  1  TX FIFO full.
- `rxd`  in  1  serial input, asynchronous.
- `txd`  out  1  serial output, idle high.
- `frame_error`  out  1  sticky: a stop bit was sampled 0.
- `parity_error`  out  1  sticky: parity mismatch (always 0 without the macro).
- `overrun`  out  1  sticky: a byte was received while the RX FIFO was full.

## Operation
- **Reset values:** `txd`=1, `t_empty`=1, `t_full`=0, `r_ready`=0, `d_out`=0, all error flags 0. FIFOs are emptied, both FSMs return to IDLE, and the tick counter is cleared.
- **Tick:** the counter runs 0..DIV-1 and `tick` pulses for one clk when it reaches DIV-1. Free-running.
- **Write:** every clk with `wrn`=0 and TX not full pushes `d_in`. A write while full is dropped silently.
- **Read:** every clk with `rdn`=0 and `r_ready`=1 pops the head. A read while empty is ignored. Any `rdn`=0 cycle clears all sticky error flags.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Leaves IDLE on the first tick with the TX FIFO non-empty, popping one entry.
  - Each state lasts 16 ticks.
  - DATA sends LSB first, DATA_BITS bits.
  - STOP sends one high bit. Back-to-back frames need no idle gap.
- **RX:** `rxd` passes through a 2-flop synchroniser.
  - IDLE: waits for the synchronised `rxd`=0 on a tick.
  - START: after 8 ticks, re-samples. If high, it is a false start → IDLE. If low, proceeds.
  - DATA: samples every 16 ticks, at mid-bit.
  - PARITY (macro only).
  - STOP: samples the stop bit.
  - At the STOP sample, the byte is pushed and `frame_error` is set if stop=0. If the FIFO is full, the byte is dropped and `overrun` is set.
  - Returns to IDLE 8 ticks early, at the stop mid-point, so it can resynchronise on the next start bit.
- **Simultaneous push and pop on a full RX FIFO:** both occur, no overrun.
- **Simultaneous write and TX pop:** both occur; occupancy is unchanged.
- **FIFO pointers:** log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full/empty are decided by comparing the MSBs.

## Timing
- TX latency: a write to an idle, empty UART drives `txd` low on the first tick after the write, i.e. ≤ DIV+1 clks.
- Frame length: (1 + DATA_BITS + P + 1)·16·DIV clks, where P=1 with parity.
- RX latency: `r_ready` rises 1 clk after the stop-bit mid-sample.
- `d_out` updates the clk after a pop.
- `t_full` and `t_empty` are registered and update the clk after the causing event.
- Reset mid-frame: `txd` returns to 1 asynchronously and the partial RX byte is discarded.

## Configuration
- `UART_PARITY_EN` defined:
  - TX inserts a parity bit after the data bits: XOR of the data, inverted if `PARITY_ODD`.
  - RX checks it; on mismatch it sets `parity_error` and still stores the byte.
- `UART_PARITY_EN` undefined: no PARITY state, frames are 8N1-style, and `parity_error` is tied to 0.

## Test plan
- DIV=4, no parity; write 0x55 → `txd`=0 for 64 clks, then 1,0,1,0,1,0,1,0 at 64 clks each, then stop 1; `t_empty` returns to 1 after the stop bit.
- `txd` looped to `rxd`; write 0x12, 0xA5, 0xFF back-to-back → `r_ready`=1 and reads return 0x12, 0xA5, 0xFF in order; no error flags set.
- Drive a frame for 0x3C with stop bit 0 → `frame_error`=1 and `d_out`=0x3C; the next `rdn` pulse clears `frame_error`.
- Loopback; send 17 bytes 0x00..0x10 with no reads, FIFO_DEPTH=16 → `overrun`=1; 16 reads return 0x00..0x0F, then `r_ready`=0.
- Pulse `rxd` low for 4 ticks only → no byte stored and the RX FSM returns to IDLE; with `UART_PARITY_EN` and PARITY_ODD=0, a frame for 0x01 with parity bit 0 → `parity_error`=1.
- Assert `I_rst_n`=0 mid-DATA of a transmit → `txd`=1 immediately, `t_empty`=1, TX FIFO empty; after release, a new write of 0xC3 transmits correctly.
